// File: rtl/alu_ctrl_pkg.sv
// ALU control codes, MIPS opcode/funct values and the issue buffer state type.
// Shared by the ALU and the decode/issue stage so both agree on the 4-bit control encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRLV = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_op_issue_if.sv
// Instruction-in / decoded-op-out bundle of the ALU issue stage.
// master = environment (register read + ALU), slave = the issuer.
interface alu_op_issue_if #(
    parameter int DATA_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       instr_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic              alu_valid_o;
    logic              alu_ready_i;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [3:0]        ctrl_o;
    logic              is_branch_o;
    logic              br_ne_o;
    logic              illegal_o;

    modport slave (
        input  in_valid_i, instr_i, rs_data_i, rt_data_i, alu_ready_i,
        output in_ready_o, alu_valid_o, src1_o, src2_o, ctrl_o,
               is_branch_o, br_ne_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, rs_data_i, rt_data_i, alu_ready_i,
        input  in_ready_o, alu_valid_o, src1_o, src2_o, ctrl_o,
               is_branch_o, br_ne_o, illegal_o
    );
endinterface

// File: rtl/alu_issue_skid.sv
// Two-entry registered buffer (EMPTY/ONE/TWO); head is always a register, so pushes show up next cycle.
// Accepts while not TWO; push and pop in ONE replaces the head, pop in TWO promotes the tail.
module alu_issue_skid
    import alu_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic         in_rdy_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o
);

    skid_state_e  r_state;
    skid_state_e  w_state_nxt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_load_head;
    logic         w_promote;
    logic         w_load_tail;

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_promote   = 1'b0;
        w_load_tail = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (push_i) begin
                    w_load_head = 1'b1;
                    w_state_nxt = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push_i && pop_i) begin
                    w_load_head = 1'b1;
                end else if (push_i) begin
                    w_load_tail = 1'b1;
                    w_state_nxt = SKID_TWO;
                end else if (pop_i) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (pop_i) begin
                    w_promote   = 1'b1;
                    w_state_nxt = SKID_ONE;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SKID_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head) begin
                r_head <= dat_i;
            end else if (w_promote) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= dat_i;
            end
        end
    end

    assign in_rdy_o  = (r_state != SKID_TWO);
    assign out_vld_o = (r_state != SKID_EMPTY);
    assign out_dat_o = r_head;

endmodule

// File: rtl/alu_op_issue.sv
// Decodes a MIPS instruction into ALU ctrl + operands and queues it in a 2-entry skid buffer.
// Legal op visible one cycle after accept; in_ready drops only when both entries are held.
module alu_op_issue
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_op_issue_if.slave  bus
);

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [3:0]        ctrl;
        logic              is_branch;
        logic              br_ne;
    } op_t;

    typedef struct packed {
        logic legal;
        op_t  op;
    } dec_t;

    function automatic dec_t decode(input logic [31:0]       instr,
                                    input logic [DATA_W-1:0] rs,
                                    input logic [DATA_W-1:0] rt);
        dec_t        d;
        logic [15:0] imm;
        imm            = instr[15:0];
        d.legal        = 1'b1;
        d.op.src1      = rs;
        d.op.src2      = rt;
        d.op.ctrl      = ALU_AND;
        d.op.is_branch = 1'b0;
        d.op.br_ne     = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADD:  d.op.ctrl = ALU_ADD;
                    FN_SUB:  d.op.ctrl = ALU_SUB;
                    FN_AND:  d.op.ctrl = ALU_AND;
                    FN_OR:   d.op.ctrl = ALU_OR;
                    FN_NOR:  d.op.ctrl = ALU_NOR;
                    FN_SLT:  d.op.ctrl = ALU_SLT;
                    FN_MULT: d.op.ctrl = ALU_MUL;
                    FN_SLL: begin
                        d.op.ctrl = ALU_SLL;
                        d.op.src1 = rt;
                        d.op.src2 = DATA_W'(instr[6 +: SHAMT_W]);
                    end
                    FN_SRLV: begin
                        d.op.ctrl = ALU_SRLV;
                        d.op.src1 = rt;
                        d.op.src2 = DATA_W'(rs[SHAMT_W-1:0]);
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                d.op.ctrl = ALU_ADD;
                d.op.src2 = {{(DATA_W-16){imm[15]}}, imm};
            end
            OP_SLTI: begin
                d.op.ctrl = ALU_SLT;
                d.op.src2 = {{(DATA_W-16){imm[15]}}, imm};
            end
            OP_ORI: begin
                d.op.ctrl = ALU_OR;
                d.op.src2 = DATA_W'(imm);
            end
            OP_BEQ, OP_BNE: begin
                d.op.ctrl      = ALU_SUB;
                d.op.is_branch = 1'b1;
                d.op.br_ne     = instr[26];
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    dec_t w_dec;
    op_t  w_head;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic r_illegal;

    assign w_dec    = decode(bus.instr_i, bus.rs_data_i, bus.rt_data_i);
    assign w_accept = bus.in_valid_i & bus.in_ready_o;
    assign w_push   = w_accept & w_dec.legal;
    assign w_pop    = bus.alu_valid_o & bus.alu_ready_i;

    alu_issue_skid #(
        .W ($bits(op_t))
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_push),
        .dat_i     (w_dec.op),
        .pop_i     (w_pop),
        .in_rdy_o  (bus.in_ready_o),
        .out_vld_o (bus.alu_valid_o),
        .out_dat_o (w_head)
    );

    // Undecodable ops are consumed without queueing; flag them for exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_dec.legal;
        end
    end

    assign bus.src1_o      = w_head.src1;
    assign bus.src2_o      = w_head.src2;
    assign bus.ctrl_o      = w_head.ctrl;
    assign bus.is_branch_o = w_head.is_branch;
    assign bus.br_ne_o     = w_head.br_ne;
    assign bus.illegal_o   = r_illegal;

endmodule
